// File: rtl/usb_aes_pkg.sv
// Shared types for the AES block packer: block geometry, FSM states, byte index.
// The PAD state only exists when PAD_PARTIAL_EN is defined.
package usb_aes_pkg;

  localparam int BLOCK_BYTES = 16;
  localparam int BLOCK_BITS  = BLOCK_BYTES * 8;

  // 0..16 inclusive, so one bit wider than a pure 0..15 index
  typedef logic [4:0] byte_idx_t;

  typedef enum logic [2:0] {
    ST_LOAD  = 3'd0,
`ifdef PAD_PARTIAL_EN
    ST_PAD   = 3'd1,
`endif
    ST_START = 3'd2,
    ST_WAIT  = 3'd3,
    ST_DRAIN = 3'd4
  } state_t;

  // Byte idx of a block, byte 0 being the most significant
  function automatic logic [7:0] block_byte(input logic [BLOCK_BITS-1:0] blk, input int idx);
    return blk[BLOCK_BITS-1-8*idx -: 8];
  endfunction

endpackage

// File: rtl/byte_serializer.sv
// Captures a 128-bit ciphertext block and emits it MSB byte first, one byte per
// cycle while the downstream FIFO has room.
module byte_serializer
  import usb_aes_pkg::*;
(
  input  logic                  clk,
  input  logic                  n_rst,
  input  logic                  load,
  input  logic [BLOCK_BITS-1:0] din,
  input  logic                  full,
  output logic                  wenable,
  output logic [7:0]            wdata,
  output logic                  last
);

  logic [BLOCK_BITS-1:0] shift_reg;
  byte_idx_t             remain_reg;

  assign wenable = (remain_reg != '0) && !full;
  assign wdata   = shift_reg[BLOCK_BITS-1 -: 8];
  assign last    = wenable && (remain_reg == byte_idx_t'(1));

  // Shifting zeros in leaves wdata at 0 once the block is fully sent
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      shift_reg  <= '0;
      remain_reg <= '0;
    end else if (load) begin
      shift_reg  <= din;
      remain_reg <= byte_idx_t'(BLOCK_BYTES);
    end else if (wenable) begin
      shift_reg  <= {shift_reg[BLOCK_BITS-9:0], 8'h00};
      remain_reg <= remain_reg - byte_idx_t'(1);
    end
  end

endmodule

// File: rtl/aes_block_packer.sv
// Packs a byte stream into 16-byte AES blocks, runs the cipher handshake and
// drains the ciphertext. Define PAD_PARTIAL_EN to zero-pad flushed partial blocks.
module aes_block_packer
  import usb_aes_pkg::*;
(
  input  logic                  clk,
  input  logic                  n_rst,
  input  logic                  data_empty,
  input  logic [7:0]            data_rdata,
  output logic                  data_renable,
  input  logic                  flush,
  output logic                  aes_start,
  output logic [BLOCK_BITS-1:0] aes_pt,
  input  logic                  aes_done,
  input  logic [BLOCK_BITS-1:0] aes_ct,
  input  logic                  enc_full,
  output logic                  enc_wenable,
  output logic [7:0]            enc_wdata,
  output logic                  busy
);

  state_t                state_reg;
  byte_idx_t             count_reg;
  logic                  flush_pending_reg;
  logic                  aes_start_reg;
  logic [BLOCK_BITS-1:0] pt_reg;
  logic [BLOCK_BITS-1:0] pt_next;
  logic                  flush_act;
  logic                  pop;
  logic                  pad_now;
  logic                  capture;
  logic                  drain_last;

  // A pending flush on a partial block wins over further pops so packets never merge
  assign flush_act = (state_reg == ST_LOAD) && flush_pending_reg && (count_reg != '0);
  assign pop       = (state_reg == ST_LOAD) && !data_empty
                     && (count_reg < byte_idx_t'(BLOCK_BYTES)) && !flush_act;
  assign capture   = (state_reg == ST_WAIT) && aes_done;

`ifdef PAD_PARTIAL_EN
  assign pad_now = (state_reg == ST_PAD);
`else
  assign pad_now = 1'b0;
`endif

  genvar gi;
  generate
    for (gi = 0; gi < BLOCK_BYTES; gi++) begin : g_pt_byte
      assign pt_next[BLOCK_BITS-1-8*gi -: 8] =
        (pop && count_reg == byte_idx_t'(gi))     ? data_rdata :
        (pad_now && count_reg <= byte_idx_t'(gi)) ? 8'h00      :
                                                    block_byte(pt_reg, gi);
    end
  endgenerate

  assign data_renable = pop;
  assign aes_start    = aes_start_reg;
  assign aes_pt       = pt_reg;
  assign busy         = (state_reg != ST_LOAD);

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_reg         <= ST_LOAD;
      count_reg         <= '0;
      flush_pending_reg <= 1'b0;
      aes_start_reg     <= 1'b0;
      pt_reg            <= '0;
    end else begin
      pt_reg <= pt_next;
      // Every LOAD cycle consumes the flag; a new flush always re-arms it
      flush_pending_reg <= flush || (flush_pending_reg && state_reg != ST_LOAD);
      case (state_reg)
        ST_LOAD: begin
          if (flush_act) begin
`ifdef PAD_PARTIAL_EN
            state_reg <= ST_PAD;
`else
            count_reg <= '0;
`endif
          end else if (pop) begin
            count_reg <= count_reg + byte_idx_t'(1);
            if (count_reg == byte_idx_t'(BLOCK_BYTES - 1)) begin
              state_reg     <= ST_START;
              aes_start_reg <= 1'b1;
            end
          end
        end
`ifdef PAD_PARTIAL_EN
        ST_PAD: begin
          count_reg     <= byte_idx_t'(BLOCK_BYTES);
          state_reg     <= ST_START;
          aes_start_reg <= 1'b1;
        end
`endif
        ST_START: begin
          aes_start_reg <= 1'b0;
          state_reg     <= ST_WAIT;
        end
        ST_WAIT: begin
          if (aes_done) state_reg <= ST_DRAIN;
        end
        ST_DRAIN: begin
          if (drain_last) begin
            state_reg <= ST_LOAD;
            count_reg <= '0;
          end
        end
        default: state_reg <= ST_LOAD;
      endcase
    end
  end

  byte_serializer u_serializer (
    .clk     (clk),
    .n_rst   (n_rst),
    .load    (capture),
    .din     (aes_ct),
    .full    (enc_full),
    .wenable (enc_wenable),
    .wdata   (enc_wdata),
    .last    (drain_last)
  );

endmodule

// File: tb/tb_aes_block_packer.sv
// Scoreboard bench for aes_block_packer: stimulus queues expected plaintext blocks
// and ciphertext bytes, a forked monitor compares every aes_start and enc write.
module tb_aes_block_packer;

  logic         clk = 1'b0;
  logic         n_rst = 1'b0;
  logic         data_empty;
  logic [7:0]   data_rdata;
  logic         data_renable;
  logic         flush = 1'b0;
  logic         aes_start;
  logic [127:0] aes_pt;
  logic         aes_done = 1'b0;
  logic [127:0] aes_ct = '0;
  logic         enc_full = 1'b0;
  logic         enc_wenable;
  logic [7:0]   enc_wdata;
  logic         busy;

  always #5 clk = ~clk;

  aes_block_packer dut (
    .clk          (clk),
    .n_rst        (n_rst),
    .data_empty   (data_empty),
    .data_rdata   (data_rdata),
    .data_renable (data_renable),
    .flush        (flush),
    .aes_start    (aes_start),
    .aes_pt       (aes_pt),
    .aes_done     (aes_done),
    .aes_ct       (aes_ct),
    .enc_full     (enc_full),
    .enc_wenable  (enc_wenable),
    .enc_wdata    (enc_wdata),
    .busy         (busy)
  );

  // First-word fall-through data FIFO model
  logic [7:0] fifo_mem [64];
  int wr_ptr = 0;
  int rd_ptr = 0;
  assign data_empty = (wr_ptr == rd_ptr);
  assign data_rdata = fifo_mem[rd_ptr[5:0]];
  always @(posedge clk) if (data_renable) rd_ptr <= rd_ptr + 1;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int total = 0, bad = 0;
  int blk_pop = 0, first_pop_cyc = 0, last_pop_cyc = 0;
  int start_count = 0, start_cyc = 0;
  int wr_count = 0, blk_wr = 0, first_wr_cyc = 0, last_wr_cyc = 0, done_cyc = 0;
  logic [127:0] exp_pt [$];
  logic [7:0]   exp_b  [$];

  localparam logic [127:0] CT1 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] CT2 = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] CT3 = 128'hdeadbeef0123456789abcdeffedcba98;
  localparam logic [127:0] CT4 = 128'h00112233445566778899aabbccddeeff;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", name, act, exp);
    end
  endtask

  task automatic monitor();
    logic [127:0] e;
    logic [7:0]   eb;
    forever begin
      @(negedge clk);
      if (n_rst) begin
        if (data_renable) begin
          if (blk_pop == 0) first_pop_cyc = cyc;
          blk_pop++;
          last_pop_cyc = cyc;
        end
        if (aes_start) begin
          start_count++;
          start_cyc = cyc;
          $display("start pt=%h", aes_pt);
          if (exp_pt.size() == 0) begin
            total++; bad++;
            $display("FAIL start_unexpected: got pt=%h want no start", aes_pt);
          end else begin
            e = exp_pt.pop_front();
            check("aes_pt", aes_pt, e);
          end
        end
        if (enc_wenable) begin
          wr_count++;
          if (blk_wr == 0) first_wr_cyc = cyc;
          blk_wr++;
          last_wr_cyc = cyc;
          $display("write byte=%h", enc_wdata);
          if (exp_b.size() == 0) begin
            total++; bad++;
            $display("FAIL write_unexpected: got %h want no write", enc_wdata);
          end else begin
            eb = exp_b.pop_front();
            check_int("enc_wdata", int'(enc_wdata), int'(eb));
          end
        end
      end
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  function automatic logic [127:0] seq_pt(input logic [7:0] first, input int n);
    logic [127:0] r = '0;
    for (int i = 0; i < 16; i++) r = {r[119:0], (i < n) ? first + 8'(i) : 8'h00};
    return r;
  endfunction

  task automatic push_seq(input logic [7:0] first, input int n);
    for (int i = 0; i < n; i++) begin
      fifo_mem[wr_ptr[5:0]] = first + 8'(i);
      wr_ptr++;
    end
  endtask

  // which: 0 = pops of this block, 1 = writes of this block
  task automatic wait_until(input int which, input int n);
    int k = 0;
    while (((which == 0) ? blk_pop : blk_wr) < n && k < 200) begin
      tick(1);
      k++;
    end
    check_int("wait_count", (which == 0) ? blk_pop : blk_wr, n);
  endtask

  task automatic wait_start(input int prev);
    int k = 0;
    while (start_count == prev && k < 100) begin
      tick(1);
      k++;
    end
    check_int("start_seen", start_count, prev + 1);
  endtask

  task automatic aes_reply(input logic [127:0] ct);
    tick(2);
    aes_ct   = ct;
    aes_done = 1'b1;
    done_cyc = cyc;
    blk_wr   = 0;
    for (int i = 0; i < 16; i++) exp_b.push_back(ct[127-8*i -: 8]);
    tick(1);
    aes_done = 1'b0;
  endtask

  task automatic wait_idle();
    int k = 0;
    while ((exp_b.size() != 0 || busy) && k < 200) begin
      tick(1);
      k++;
    end
    check_int("drain_left", exp_b.size(), 0);
    check_int("busy_idle", int'(busy), 0);
  endtask

  task automatic run_block(input logic [7:0] first, input logic [127:0] ct);
    int p = start_count;
    blk_pop = 0;
    exp_pt.push_back(seq_pt(first, 16));
    push_seq(first, 16);
    wait_start(p);
    check_int("pop_span", last_pop_cyc - first_pop_cyc, 15);
    check_int("start_latency", start_cyc - last_pop_cyc, 1);
    aes_reply(ct);
    wait_idle();
    check_int("first_write", first_wr_cyc - done_cyc, 1);
    check_int("write_span", last_wr_cyc - first_wr_cyc, 15);
    check_int("block_writes", blk_wr, 16);
  endtask

  initial begin
    int p;
    int w;
    fork
      monitor();
    join_none

    tick(2);
    check_int("rst_renable", int'(data_renable), 0);
    check_int("rst_start", int'(aes_start), 0);
    check_int("rst_wenable", int'(enc_wenable), 0);
    check_int("rst_busy", int'(busy), 0);
    check_int("rst_wdata", int'(enc_wdata), 0);
    check("rst_pt", aes_pt, '0);
    n_rst = 1'b1;
    tick(2);

    // Full block, no backpressure
    run_block(8'h00, CT1);

    // Backpressure at byte 5 for three cycles
    p = start_count;
    blk_pop = 0;
    exp_pt.push_back(seq_pt(8'h50, 16));
    push_seq(8'h50, 16);
    wait_start(p);
    aes_reply(CT2);
    wait_until(1, 5);
    enc_full = 1'b1;
    tick(1);
    check_int("stall_wenable", int'(enc_wenable), 0);
    tick(2);
    enc_full = 1'b0;
    wait_idle();
    check_int("stall_writes", blk_wr, 16);

    // Partial packet of five bytes closed by flush
    p = start_count;
    blk_pop = 0;
`ifdef PAD_PARTIAL_EN
    exp_pt.push_back(seq_pt(8'ha1, 5));
`endif
    push_seq(8'ha1, 5);
    wait_until(0, 5);
    tick(1);
    flush = 1'b1;
    tick(1);
    flush = 1'b0;
`ifdef PAD_PARTIAL_EN
    wait_start(p);
    aes_reply(CT3);
    wait_idle();
`else
    tick(10);
    check_int("partial_no_start", start_count, p);
    check_int("partial_busy", int'(busy), 0);
`endif
    run_block(8'h10, CT3);

    // Flush on the same edge as the 16th pop
    p = start_count;
    blk_pop = 0;
    exp_pt.push_back(seq_pt(8'h20, 16));
    push_seq(8'h20, 16);
    wait_until(0, 15);
    flush = 1'b1;
    tick(1);
    flush = 1'b0;
    wait_start(p);
    check_int("flush16_latency", start_cyc - last_pop_cyc, 1);
    aes_reply(CT4);
    wait_idle();
    p = start_count;
    tick(12);
    check_int("flush16_no_extra", start_count, p);

    // Reset after the 7th drained byte
    p = start_count;
    blk_pop = 0;
    exp_pt.push_back(seq_pt(8'h30, 16));
    push_seq(8'h30, 16);
    wait_start(p);
    aes_reply(CT1);
    wait_until(1, 7);
    n_rst = 1'b0;
    #1;
    check_int("mid_rst_wenable", int'(enc_wenable), 0);
    check_int("mid_rst_wdata", int'(enc_wdata), 0);
    check_int("mid_rst_busy", int'(busy), 0);
    check_int("mid_rst_start", int'(aes_start), 0);
    check_int("mid_rst_renable", int'(data_renable), 0);
    check("mid_rst_pt", aes_pt, '0);
    exp_b.delete();
    tick(2);
    n_rst = 1'b1;
    tick(1);
    w = wr_count;
    aes_ct   = CT2;
    aes_done = 1'b1;
    tick(1);
    aes_done = 1'b0;
    tick(10);
    check_int("stray_done_writes", wr_count, w);
    check_int("stray_done_busy", int'(busy), 0);
    run_block(8'h40, CT2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish want finish");
    $fatal(1, "timeout");
  end

endmodule
